bpu_btb: RTL and testbench

Parametrised branch predictor for the five-stage pipeline. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The IF stage looks up the current PC in the same cycle and gets a predicted next PC. EX then reports each resolved branch or jump back to the block. This turns the fixed "predict not-taken, flush IF/ID and ID/EX on every taken branch" policy into a trained prediction, and the block flags mispredictions so the existing control-hazard flush logic can act on them.

---
 rtl/bpu_btb.sv | 133 +++++++++++++
 tb/tb_bpu_btb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped BTB with 2-bit saturating counters for the 5-stage pipe.
// Optional macro BPU_PERF_EN adds perf_branches / perf_mispred counters.
module bpu_btb #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_if,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_is_jump,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
`ifdef BPU_PERF_EN
   output logic [31:0]       perf_branches,
   output logic [31:0]       perf_mispred,
`endif
   output logic [ADDR_W-1:0] redirect_pc
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag [ENTRIES];
   logic [ADDR_W-1:0]  r_tgt [ENTRIES];
   logic [1:0]         r_cnt [ENTRIES];

   logic [IDX_W-1:0]  w_lidx;
   logic [TAG_W-1:0]  w_ltag;
   logic              w_lhit;
   logic [IDX_W-1:0]  w_uidx;
   logic [TAG_W-1:0]  w_utag;
   logic              w_uhit;
   logic [1:0]        w_ucnt;
   logic [1:0]        w_cnt_nxt;
   logic              w_wr_cnt;
   logic              w_wr_tt;
   logic [ADDR_W-1:0] w_actual_npc;
   logic              w_unused;

   assign w_unused = &{1'b0, pc_if[1:0], upd_pc[1:0], upd_pred_taken};

   // lookup reads only registered state, so a same-cycle update is not seen
   assign w_lidx      = pc_if[IDX_W+1:2];
   assign w_ltag      = pc_if[ADDR_W-1:IDX_W+2];
   assign w_lhit      = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
   assign pred_taken  = w_lhit && r_cnt[w_lidx][1];
   assign pred_target = pred_taken ? r_tgt[w_lidx] : pc_if + FOUR;

   assign w_uidx = upd_pc[IDX_W+1:2];
   assign w_utag = upd_pc[ADDR_W-1:IDX_W+2];
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
   assign w_ucnt = r_cnt[w_uidx];

   assign w_actual_npc = upd_taken ? upd_target : upd_pc + FOUR;
   assign redirect_pc  = w_actual_npc;
   assign mispredict   = upd_valid && (w_actual_npc != upd_pred_target);

   always_comb begin
      w_cnt_nxt = w_ucnt;
      w_wr_cnt  = 1'b0;
      w_wr_tt   = 1'b0;
      if (upd_valid) begin
         if (w_uhit) begin
            w_wr_cnt = 1'b1;
            if (upd_is_jump) begin
               w_cnt_nxt = 2'b11;
               w_wr_tt   = 1'b1;
            end else if (upd_taken) begin
               w_cnt_nxt = (w_ucnt == 2'b11) ? 2'b11 : w_ucnt + 2'b01;
               w_wr_tt   = 1'b1;
            end else begin
               w_cnt_nxt = (w_ucnt == 2'b00) ? 2'b00 : w_ucnt - 2'b01;
            end
         end else if (upd_taken) begin
            w_wr_cnt  = 1'b1;
            w_wr_tt   = 1'b1;
            w_cnt_nxt = upd_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_cnt[i] <= 2'b00;
         end
      end else if (w_wr_cnt) begin
         r_valid[w_uidx] <= 1'b1;
         r_cnt[w_uidx]   <= w_cnt_nxt;
      end
   end

   // tags and targets need no reset; valid bits gate them
   always_ff @(posedge clk) begin
      if (!rst && w_wr_tt) begin
         r_tag[w_uidx] <= w_utag;
         r_tgt[w_uidx] <= upd_target;
      end
   end

`ifdef BPU_PERF_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_mp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_br <= '0;
         r_perf_mp <= '0;
      end else begin
         if (upd_valid && (r_perf_br != 32'hFFFF_FFFF)) begin
            r_perf_br <= r_perf_br + 32'd1;
         end
         if (mispredict && (r_perf_mp != 32'hFFFF_FFFF)) begin
            r_perf_mp <= r_perf_mp + 32'd1;
         end
      end
   end

   assign perf_branches = r_perf_br;
   assign perf_mispred  = r_perf_mp;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// tb_bpu_btb: table-driven vectors with an expected-result queue for bpu_btb.
// Define BPU_PERF_EN to also exercise the perf counters.
module tb_bpu_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
`ifdef BPU_PERF_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispred;
`endif

   int total = 0;
   int bad   = 0;

   bpu_btb #(.ENTRIES(16), .ADDR_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .pc_if(pc_if),
      .pred_taken(pred_taken),
      .pred_target(pred_target),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken),
      .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(mispredict),
`ifdef BPU_PERF_EN
      .perf_branches(perf_branches),
      .perf_mispred(perf_mispred),
`endif
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        uj;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptg;
      logic        e_pt;
      logic [31:0] e_ptg;
      logic        e_mp;
      logic [31:0] e_rd;
   } vec_t;

   typedef struct {
      int          id;
      logic        pt;
      logic [31:0] ptg;
      logic        mp;
      logic [31:0] rd;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];

   function automatic vec_t mk(
      logic [31:0] pc, logic uv, logic [31:0] upc, logic uj, logic ut,
      logic [31:0] utgt, logic upt, logic [31:0] uptg,
      logic e_pt, logic [31:0] e_ptg, logic e_mp, logic [31:0] e_rd);
      vec_t v;
      v.pc = pc; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut;
      v.utgt = utgt; v.upt = upt; v.uptg = uptg;
      v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_mp = e_mp; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s v%0d: got %h want %h", name, id, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      pc_if = v.pc; upd_valid = v.uv; upd_pc = v.upc;
      upd_is_jump = v.uj; upd_taken = v.ut; upd_target = v.utgt;
      upd_pred_taken = v.upt; upd_pred_target = v.uptg;
   endtask

   task automatic idle();
      upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
      upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
   endtask

   task automatic apply(int id, vec_t v);
      exp_t e;
      exp_t g;
      @(negedge clk);
      drive(v);
      e.id = id; e.pt = v.e_pt; e.ptg = v.e_ptg; e.mp = v.e_mp; e.rd = v.e_rd;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      chk("pred_taken", g.id, {31'b0, pred_taken}, {31'b0, g.pt});
      chk("pred_target", g.id, pred_target, g.ptg);
      chk("mispredict", g.id, {31'b0, mispredict}, {31'b0, g.mp});
      chk("redirect_pc", g.id, redirect_pc, g.rd);
   endtask

   initial begin
      //            pc_if  uv upc   uj ut utgt  upt uptg   pt ptg  mp rd
      tv.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
      tv.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 1, 32'h80,  0, 32'h104));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
      tv.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104));
      tv.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4));
      tv.push_back(mk(32'h140, 1, 32'h100, 0, 1, 32'h80,  0, 32'h80,  0, 32'h144, 0, 32'h80));
      tv.push_back(mk(32'h140, 1, 32'h140, 0, 1, 32'h40,  0, 32'h144, 0, 32'h144, 1, 32'h40));
      tv.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4));
      tv.push_back(mk(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h40,  0, 32'h4));
      tv.push_back(mk(32'h180, 1, 32'h180, 0, 0, 32'h0,   0, 32'h184, 0, 32'h184, 0, 32'h184));
      tv.push_back(mk(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h40,  0, 32'h4));
      tv.push_back(mk(32'h180, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h184, 0, 32'h4));
      tv.push_back(mk(32'h200, 1, 32'h200, 1, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300));
      tv.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4));
      tv.push_back(mk(32'h200, 1, 32'h200, 1, 1, 32'h400, 1, 32'h300, 1, 32'h300, 1, 32'h400));
      tv.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h4));
      tv.push_back(mk(32'h204, 1, 32'h204, 1, 1, 32'h10,  0, 32'h208, 0, 32'h208, 1, 32'h10));
      tv.push_back(mk(32'h204, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0, 32'h4));
      tv.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h4));
      tv.push_back(mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h5,
                      0, 32'h3, 0, 32'h0));

      rst = 1'b1;
      pc_if = 32'h100;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         apply(i, tv[i]);
      end

      // reset on the same edge as a jump update: update discarded, table cleared
      @(negedge clk);
      rst = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h208; upd_is_jump = 1'b1;
      upd_taken = 1'b1; upd_target = 32'h500; upd_pred_target = 32'h20C;
      @(negedge clk);
      rst = 1'b0;
      idle();
      pc_if = 32'h208;
      #1;
      chk("rst_drop_pt", 100, {31'b0, pred_taken}, 32'h0);
      chk("rst_drop_ptg", 100, pred_target, 32'h20C);
      pc_if = 32'h200;
      #1;
      chk("rst_clr_pt", 101, {31'b0, pred_taken}, 32'h0);
      chk("rst_clr_ptg", 101, pred_target, 32'h204);
      chk("rst_mp", 101, {31'b0, mispredict}, 32'h0);

`ifdef BPU_PERF_EN
      chk("perf_br_rst", 102, perf_branches, 32'd0);
      chk("perf_mp_rst", 102, perf_mispred, 32'd0);
      apply(103, mk(32'h0, 1, 32'h40, 0, 0, 32'h0,  0, 32'h44, 0, 32'h4, 0, 32'h44));
      apply(104, mk(32'h0, 1, 32'h40, 0, 1, 32'h10, 0, 32'h44, 0, 32'h4, 1, 32'h10));
      apply(105, mk(32'h0, 1, 32'h40, 0, 1, 32'h10, 1, 32'h10, 0, 32'h4, 0, 32'h10));
      apply(106, mk(32'h0, 1, 32'h40, 1, 1, 32'h20, 1, 32'h10, 0, 32'h4, 1, 32'h20));
      apply(107, mk(32'h0, 1, 32'h44, 0, 0, 32'h0,  0, 32'h48, 0, 32'h4, 0, 32'h48));
      @(negedge clk);
      idle();
      #1;
      chk("perf_branches", 108, perf_branches, 32'd5);
      chk("perf_mispred", 108, perf_mispred, 32'd2);
      @(negedge clk);
      rst = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      upd_target = 32'h99C; upd_pred_target = 32'h44;
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1;
      chk("perf_br_clr", 109, perf_branches, 32'd0);
      chk("perf_mp_clr", 109, perf_mispred, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
